// File: rtl/procedural_serial_unload_if.sv
// Word-source-to-shifter bundle for procedural_serial_unload.
// Handshake: a word transfers at the posedge where load && ready are both 1;
// Din is sampled only then, and load while ready=0 has no effect.
interface procedural_serial_unload_if #(
  parameter int WIDTH = 5
);
  logic             load;
  logic [WIDTH-1:0] Din;
  logic             E;
  logic             ready;
  logic             busy;
  logic             Q;
  logic             done;

  modport master (
    output load, Din, E,
    input  ready, busy, Q, done
  );

  modport slave (
    input  load, Din, E,
    output ready, busy, Q, done
  );
endinterface

// File: rtl/procedural_serial_unload.sv
// Parallel-in / serial-out transmitter for the serial-load link.
// Optional feature macro: PARITY_EN appends an even-parity bit after the data bits.
module procedural_serial_unload #(
  parameter int WIDTH     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        clr,
  procedural_serial_unload_if.slave   bus,
  output logic [1:0]                  dbg_state
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int OUT = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    bitcnt, bitcnt_n;
  logic             done_q, done_n;
`ifdef PARITY_EN
  logic             par, par_n;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      done_q <= 1'b0;
`ifdef PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      bitcnt <= bitcnt_n;
      done_q <= done_n;
`ifdef PARITY_EN
      par    <= par_n;
`endif
    end
  end

  // shreg is cleared whenever the word ends, so its output bit doubles as Q
  // in every state and Q stays a bare flop output.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    done_n   = 1'b0;
`ifdef PARITY_EN
    par_n    = par;
`endif
    case (state)
      IDLE: begin
        if (bus.load) begin
          shreg_n  = bus.Din;
          bitcnt_n = '0;
          state_n  = SHIFT;
`ifdef PARITY_EN
          par_n    = ^bus.Din;
`endif
        end
      end
      SHIFT: begin
        if (bus.E) begin
          if (bitcnt == LAST) begin
            shreg_n = '0;
`ifdef PARITY_EN
            // Parity rides out through the same output bit position.
            shreg_n[OUT] = par;
            state_n      = PAR;
`else
            state_n = IDLE;
            done_n  = 1'b1;
`endif
          end else begin
            shreg_n  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            bitcnt_n = bitcnt + CW'(1);
          end
        end
      end
`ifdef PARITY_EN
      PAR: begin
        if (bus.E) begin
          shreg_n = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.Q     = shreg[OUT];
  assign bus.done  = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_procedural_serial_unload.sv
// Directed + randomized bench for procedural_serial_unload with a receiver model.
module tb_procedural_serial_unload;

  localparam int W         = 5;
  localparam bit MSB_FIRST = 1'b1;
`ifdef PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic       clk;
  logic       clr;
  logic [1:0] dbg_state;
  int         tests;
  int         fails;
  logic       exp_q[$];

  procedural_serial_unload_if #(.WIDTH(W)) bus ();

  procedural_serial_unload #(.WIDTH(W), .MSB_FIRST(MSB_FIRST)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of the line sequence for a word: data bits in link order, then parity.
  function automatic logic exp_bit(input logic [W-1:0] w, input int i);
    if (i >= W) return ^w;
    return MSB_FIRST ? w[W-1-i] : w[i];
  endfunction

  // Send one word; mode 0: E always 1, 1: E pattern 1,0,0,..., 2: random E.
  task automatic xfer(input logic [W-1:0] word, input int mode);
    logic [W-1:0] rx;
    int cyc;
    int taken;
    chk("ready_before_load", bus.ready, 1);
    bus.load = 1'b1;
    bus.Din  = word;
    bus.E    = 1'($urandom_range(0, 1));
    for (int i = 0; i < NBITS; i++) exp_q.push_back(exp_bit(word, i));
    tick;
    rx    = '0;
    cyc   = 0;
    taken = 0;
    while (taken < NBITS) begin
      bus.load = 1'($urandom_range(0, 1));
      bus.Din  = W'($urandom);
      case (mode)
        0:       bus.E = 1'b1;
        1:       bus.E = (cyc % 3 == 0);
        default: bus.E = (cyc >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      chk("q_bit", bus.Q, exp_q[0]);
      chk("busy_in_word", bus.busy, 1);
      chk("ready_in_word", bus.ready, 0);
      chk("done_in_word", bus.done, 0);
      if (bus.E) begin
        if (taken < W) rx = {rx[W-2:0], bus.Q};
        void'(exp_q.pop_front());
        taken++;
      end
      tick;
      cyc++;
    end
    bus.load = 1'b0;
    bus.E    = 1'($urandom_range(0, 1));
    chk("done_pulse", bus.done, 1);
    chk("ready_at_done", bus.ready, 1);
    chk("busy_at_done", bus.busy, 0);
    chk("q_at_done", bus.Q, 0);
    chk("rx_word", rx, word);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.load = 1'b0;
      bus.E    = 1'($urandom_range(0, 1));
      bus.Din  = W'($urandom);
      tick;
      chk("idle_done", bus.done, 0);
      chk("idle_ready", bus.ready, 1);
      chk("idle_busy", bus.busy, 0);
      chk("idle_q", bus.Q, 0);
    end
  endtask

  // Load a word, shift k bits, then reset mid-word.
  task automatic abort_word(input logic [W-1:0] word, input int k);
    bus.load = 1'b1;
    bus.Din  = word;
    tick;
    bus.load = 1'b0;
    for (int i = 0; i < k; i++) begin
      bus.E = 1'b1;
      chk("abort_q_bit", bus.Q, exp_bit(word, i));
      tick;
    end
    clr      = 1'b1;
    bus.load = 1'b1;
    bus.E    = 1'b1;
    tick;
    chk("abort_ready", bus.ready, 1);
    chk("abort_busy", bus.busy, 0);
    chk("abort_q", bus.Q, 0);
    chk("abort_done", bus.done, 0);
    clr      = 1'b0;
    bus.load = 1'b0;
    tick;
    chk("abort_no_done", bus.done, 0);
    chk("abort_q_after", bus.Q, 0);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    clr      = 1'b1;
    bus.load = 1'b1;
    bus.E    = 1'b1;
    bus.Din  = 5'b10110;

    // reset held with load and E active
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("rst_ready", bus.ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_q", bus.Q, 0);
      chk("rst_done", bus.done, 0);
    end
    clr      = 1'b0;
    bus.load = 1'b0;
    idle(1);

    xfer(5'b10110, 0);
    idle(2);
    xfer(5'b10110, 1);
    // back-to-back: load in the done cycle
    xfer(5'b01001, 0);
    idle(1);
    abort_word(5'b11111, 2);
    idle(2);

    for (int n = 0; n < 30; n++) begin
      xfer(W'($urandom), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
